// File: rtl/decimal_entry_to_signed.sv
// decimal_entry_to_signed: keypad-style signed decimal entry. Collects up to
// NUM_DIGITS BCD digits plus a sign, converts the magnitude MSD-first with a
// shift-add multiply-accumulate, range-checks against VAL_W two's complement
// and presents the result with a one-cycle val_valid pulse.
// Optional build macro: DEC_ENTRY_SATURATE_EN -- out-of-range results saturate
// to the nearest representable value instead of being forced to zero.
module decimal_entry_to_signed #(
   parameter int unsigned NUM_DIGITS = 3,
   parameter int unsigned VAL_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             digit_valid,
   input  logic [3:0]       digit,
   input  logic             neg_toggle,
   input  logic             clear,
   input  logic             enter,
   output logic [3:0]       bcd_dig0,
   output logic [3:0]       bcd_dig1,
   output logic [3:0]       bcd_dig2,
   output logic             entry_neg,
   output logic             busy,
   output logic [VAL_W-1:0] val,
   output logic             val_valid,
   output logic             overflow
);

   localparam int unsigned DIG_W   = 4;
   localparam int unsigned ACC_W   = $clog2(10 ** NUM_DIGITS);
   localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W   = $clog2(NUM_DIGITS + 1);
   localparam int unsigned POS_MAX = (2 ** (VAL_W - 1)) - 1;
   localparam int unsigned NEG_MAX = 2 ** (VAL_W - 1);

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [DIG_W-1:0]   dig     [NUM_DIGITS];
   logic [DIG_W-1:0]   dig_nxt [NUM_DIGITS];
   logic [CNT_W-1:0]   count, count_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [ACC_W-1:0]   acc, acc_nxt;
   logic [ACC_W-1:0]   acc_mac;
   logic [DIG_W-1:0]   cur_dig;
   logic               neg_nxt;
   logic               busy_nxt;
   logic [VAL_W-1:0]   val_nxt;
   logic               val_valid_nxt;
   logic               overflow_nxt;
   logic [VAL_W-1:0]   ovf_val;

   // Echo the entry buffer to the seven-segment path.
   assign bcd_dig0 = dig[0];
   assign bcd_dig1 = dig[1];
   assign bcd_dig2 = dig[2];

   // Select the digit addressed by the conversion index.
   always_comb begin
      cur_dig = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) cur_dig = dig[i];
      end
   end

   // acc*10 + digit using shifts only; acc < 10^(N-1) here so nothing is lost.
   assign acc_mac = (acc << 3) + (acc << 1) + ACC_W'(cur_dig);

   // Value substituted when the magnitude does not fit the signed range.
`ifdef DEC_ENTRY_SATURATE_EN
   assign ovf_val = entry_neg ? {1'b1, {(VAL_W-1){1'b0}}} : {1'b0, {(VAL_W-1){1'b1}}};
`else
   assign ovf_val = '0;
`endif

   // Next-state and next-value logic for the entry/convert/done sequence.
   always_comb begin
      state_nxt     = state;
      dig_nxt       = dig;
      count_nxt     = count;
      idx_nxt       = idx;
      acc_nxt       = acc;
      neg_nxt       = entry_neg;
      val_nxt       = val;
      overflow_nxt  = overflow;
      val_valid_nxt = 1'b0;

      case (state)
         ENTRY: begin
            if (clear) begin
               for (int i = 0; i < NUM_DIGITS; i++) dig_nxt[i] = '0;
               count_nxt = '0;
               neg_nxt   = 1'b0;
            end else if (enter) begin
               acc_nxt   = '0;
               idx_nxt   = IDX_W'(NUM_DIGITS - 1);
               state_nxt = CONVERT;
            end else if (neg_toggle) begin
               neg_nxt = ~entry_neg;
            end else if (digit_valid && (digit <= 4'd9) && (count < CNT_W'(NUM_DIGITS))) begin
               for (int i = NUM_DIGITS - 1; i > 0; i--) dig_nxt[i] = dig[i-1];
               dig_nxt[0] = digit;
               count_nxt  = count + CNT_W'(1);
            end
         end

         CONVERT: begin
            acc_nxt = acc_mac;
            idx_nxt = idx - IDX_W'(1);
            if (idx == '0) begin
               // Final digit: range-check the completed magnitude now so
               // val/overflow/val_valid become visible together in DONE.
               state_nxt     = DONE;
               val_valid_nxt = 1'b1;
               if (!entry_neg) begin
                  if (32'(acc_mac) <= POS_MAX) begin
                     val_nxt      = VAL_W'(acc_mac);
                     overflow_nxt = 1'b0;
                  end else begin
                     val_nxt      = ovf_val;
                     overflow_nxt = 1'b1;
                  end
               end else begin
                  if (32'(acc_mac) <= NEG_MAX) begin
                     val_nxt      = VAL_W'(0) - VAL_W'(acc_mac);
                     overflow_nxt = 1'b0;
                  end else begin
                     val_nxt      = ovf_val;
                     overflow_nxt = 1'b1;
                  end
               end
            end
         end

         DONE: begin
            for (int i = 0; i < NUM_DIGITS; i++) dig_nxt[i] = '0;
            count_nxt = '0;
            neg_nxt   = 1'b0;
            state_nxt = ENTRY;
         end

         default: begin
            state_nxt = ENTRY;
         end
      endcase

      busy_nxt = (state_nxt != ENTRY);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ENTRY;
         for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= '0;
         count     <= '0;
         idx       <= '0;
         acc       <= '0;
         entry_neg <= 1'b0;
         busy      <= 1'b0;
         val       <= '0;
         val_valid <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_nxt;
         for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= dig_nxt[i];
         count     <= count_nxt;
         idx       <= idx_nxt;
         acc       <= acc_nxt;
         entry_neg <= neg_nxt;
         busy      <= busy_nxt;
         val       <= val_nxt;
         val_valid <= val_valid_nxt;
         overflow  <= overflow_nxt;
      end
   end

endmodule

// File: tb/tb_decimal_entry_to_signed.sv
// Directed bench for decimal_entry_to_signed; expected values follow
// DEC_ENTRY_SATURATE_EN when the macro is defined for the build.
module tb_decimal_entry_to_signed;

   logic       clk = 1'b0;
   logic       rst;
   logic       digit_valid;
   logic [3:0] digit;
   logic       neg_toggle;
   logic       clear;
   logic       enter;
   logic [3:0] bcd_dig0, bcd_dig1, bcd_dig2;
   logic       entry_neg;
   logic       busy;
   logic [7:0] val;
   logic       val_valid;
   logic       overflow;

   int checks = 0;
   int errors = 0;

`ifdef DEC_ENTRY_SATURATE_EN
   localparam logic [7:0] OVF_POS = 8'h7F;
   localparam logic [7:0] OVF_NEG = 8'h80;
`else
   localparam logic [7:0] OVF_POS = 8'h00;
   localparam logic [7:0] OVF_NEG = 8'h00;
`endif

   decimal_entry_to_signed dut (
      .clk        (clk),
      .rst        (rst),
      .digit_valid(digit_valid),
      .digit      (digit),
      .neg_toggle (neg_toggle),
      .clear      (clear),
      .enter      (enter),
      .bcd_dig0   (bcd_dig0),
      .bcd_dig1   (bcd_dig1),
      .bcd_dig2   (bcd_dig2),
      .entry_neg  (entry_neg),
      .busy       (busy),
      .val        (val),
      .val_valid  (val_valid),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Stimulus helpers: called 1 time unit after a rising edge, return likewise.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      digit = d; digit_valid = 1'b1;
      step();
      digit_valid = 1'b0;
   endtask

   task automatic toggle_neg();
      neg_toggle = 1'b1;
      step();
      neg_toggle = 1'b0;
   endtask

   // Pulse enter and count edges until val_valid (lat = -1 on timeout).
   task automatic enter_wait(output int lat);
      enter = 1'b1;
      step();
      enter = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (val_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({bcd_dig2, bcd_dig1, bcd_dig0, entry_neg, busy, val, val_valid, overflow} !== 22'd0) begin
         errors++;
         $display("FAIL reset_state: got dig=%h%h%h neg=%b busy=%b val=%h vv=%b ovf=%b, expected all 0",
                  bcd_dig2, bcd_dig1, bcd_dig0, entry_neg, busy, val, val_valid, overflow);
      end
   endtask

   task automatic test_pos_max();
      int lat;
      press(4'd1); press(4'd2); press(4'd7);
      checks++;
      if ({bcd_dig2, bcd_dig1, bcd_dig0} !== 12'h127) begin
         errors++; $display("FAIL pos_echo: got %h%h%h, expected 127", bcd_dig2, bcd_dig1, bcd_dig0);
      end
      enter_wait(lat);
      checks++;
      if (lat !== 3) begin
         errors++; $display("FAIL pos_latency: got %0d edges after enter, expected 3", lat);
      end
      checks++;
      if ({val, overflow, busy} !== {8'h7F, 1'b0, 1'b1}) begin
         errors++; $display("FAIL pos_result: got val=%h ovf=%b busy=%b, expected 7f 0 1", val, overflow, busy);
      end
      step();
      checks++;
      if ({val_valid, busy, bcd_dig2, bcd_dig1, bcd_dig0, val} !== {2'b00, 12'h000, 8'h7F}) begin
         errors++;
         $display("FAIL pos_after_done: got vv=%b busy=%b dig=%h%h%h val=%h, expected 0 0 000 7f",
                  val_valid, busy, bcd_dig2, bcd_dig1, bcd_dig0, val);
      end
   endtask

   task automatic test_neg_min();
      int lat;
      toggle_neg();
      press(4'd1); press(4'd2); press(4'd8);
      checks++;
      if (entry_neg !== 1'b1) begin
         errors++; $display("FAIL neg_echo: got entry_neg=%b, expected 1", entry_neg);
      end
      enter_wait(lat);
      checks++;
      if ({lat == 3, val, overflow} !== {1'b1, 8'h80, 1'b0}) begin
         errors++; $display("FAIL neg_min: got lat=%0d val=%h ovf=%b, expected 3 80 0", lat, val, overflow);
      end
      step();
      checks++;
      if (entry_neg !== 1'b0) begin
         errors++; $display("FAIL neg_cleared: got entry_neg=%b, expected 0", entry_neg);
      end
   endtask

   task automatic test_overflow();
      int lat;
      press(4'd2); press(4'd5); press(4'd5);
      enter_wait(lat);
      checks++;
      if ({lat == 3, val, overflow} !== {1'b1, OVF_POS, 1'b1}) begin
         errors++; $display("FAIL ovf_pos_255: got lat=%0d val=%h ovf=%b, expected 3 %h 1", lat, val, overflow, OVF_POS);
      end
      step();
      toggle_neg();
      press(4'd1); press(4'd2); press(4'd9);
      enter_wait(lat);
      checks++;
      if ({lat == 3, val, overflow} !== {1'b1, OVF_NEG, 1'b1}) begin
         errors++; $display("FAIL ovf_neg_129: got lat=%0d val=%h ovf=%b, expected 3 %h 1", lat, val, overflow, OVF_NEG);
      end
      step();
   endtask

   task automatic test_buffer_limits();
      press(4'd4); press(4'd5); press(4'd6); press(4'd7); press(4'hC);
      checks++;
      if ({bcd_dig2, bcd_dig1, bcd_dig0} !== 12'h456) begin
         errors++; $display("FAIL buffer_full: got %h%h%h, expected 456", bcd_dig2, bcd_dig1, bcd_dig0);
      end
      toggle_neg();
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if ({bcd_dig2, bcd_dig1, bcd_dig0, entry_neg, val, overflow} !== {12'h000, 1'b0, OVF_NEG, 1'b1}) begin
         errors++;
         $display("FAIL clear_entry: got dig=%h%h%h neg=%b val=%h ovf=%b, expected 000 0 %h 1",
                  bcd_dig2, bcd_dig1, bcd_dig0, entry_neg, val, overflow, OVF_NEG);
      end
      press(4'hA); press(4'd9);
      checks++;
      if ({bcd_dig2, bcd_dig1, bcd_dig0} !== 12'h009) begin
         errors++; $display("FAIL digit_range: got %h%h%h, expected 009", bcd_dig2, bcd_dig1, bcd_dig0);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic test_small_values();
      int lat;
      press(4'd4); press(4'd2);
      enter_wait(lat);
      checks++;
      if ({lat == 3, val, overflow} !== {1'b1, 8'h2A, 1'b0}) begin
         errors++; $display("FAIL two_digits_42: got lat=%0d val=%h ovf=%b, expected 3 2a 0", lat, val, overflow);
      end
      step();
      toggle_neg();
      press(4'd5);
      enter_wait(lat);
      checks++;
      if ({lat == 3, val, overflow} !== {1'b1, 8'hFB, 1'b0}) begin
         errors++; $display("FAIL neg_5: got lat=%0d val=%h ovf=%b, expected 3 fb 0", lat, val, overflow);
      end
      step();
   endtask

   task automatic test_enter_clear();
      press(4'd3);
      enter = 1'b1; clear = 1'b1;
      step();
      enter = 1'b0; clear = 1'b0;
      checks++;
      if ({busy, bcd_dig0, val} !== {1'b0, 4'd0, 8'hFB}) begin
         errors++; $display("FAIL enter_clear: got busy=%b dig0=%h val=%h, expected 0 0 fb", busy, bcd_dig0, val);
      end
   endtask

   task automatic test_rst_mid_convert();
      bit seen;
      press(4'd9); press(4'd9);
      enter = 1'b1;
      step();
      enter = 1'b0;
      // Inputs during conversion must be ignored.
      digit = 4'd5; digit_valid = 1'b1; clear = 1'b1;
      step();
      digit_valid = 1'b0; clear = 1'b0;
      checks++;
      if ({busy, bcd_dig1, bcd_dig0} !== {1'b1, 8'h99}) begin
         errors++; $display("FAIL busy_ignores: got busy=%b dig=%h%h, expected 1 99", busy, bcd_dig1, bcd_dig0);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bcd_dig2, bcd_dig1, bcd_dig0, entry_neg, busy, val, val_valid, overflow} !== 22'd0) begin
         errors++;
         $display("FAIL rst_mid: got dig=%h%h%h neg=%b busy=%b val=%h vv=%b ovf=%b, expected all 0",
                  bcd_dig2, bcd_dig1, bcd_dig0, entry_neg, busy, val, val_valid, overflow);
      end
      step();
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (val_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL rst_no_valid: got val_valid pulse=%b, expected 0", seen);
      end
   endtask

   task automatic test_empty_neg();
      int lat;
      press(4'd3);
      enter_wait(lat);
      step();
      toggle_neg();
      enter_wait(lat);
      checks++;
      if ({lat == 3, val, overflow} !== {1'b1, 8'h00, 1'b0}) begin
         errors++; $display("FAIL empty_neg: got lat=%0d val=%h ovf=%b, expected 3 00 0", lat, val, overflow);
      end
      step();
   endtask

   initial begin
      rst = 1'b1; digit_valid = 1'b0; digit = 4'd0;
      neg_toggle = 1'b0; clear = 1'b0; enter = 1'b0;
      #12;
      test_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      step();
      test_pos_max();
      test_neg_min();
      test_overflow();
      test_buffer_limits();
      test_small_values();
      test_enter_clear();
      test_rst_mid_convert();
      test_empty_neg();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
